// File: rtl/mc_sequencer_if.sv
// rtl/mc_sequencer_if.sv - instruction/data memory handshake bundle for mc_sequencer
interface mc_sequencer_if #(
  parameter int DWIDTH = 32
);
  logic              imem_req;
  logic [DWIDTH-1:0] imem_addr;
  logic              imem_ack;
  logic [DWIDTH-1:0] imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;

  // Sequencer side: issues requests, consumes acks and fetched data.
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  // Memory side: answers requests.
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle fetch/exec/mem/writeback control sequencer
module mc_sequencer #(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_sequencer_if.master    bus,
  output logic [DWIDTH-1:0] instr,
  input  logic [2:0]        jump_type,
  input  logic [DWIDTH-1:0] jump_addr,
  input  logic [DWIDTH-1:0] imm,
  input  logic              alu_zero,
  input  logic [DWIDTH-1:0] rs1_data,
  input  logic              we_dmem,
  input  logic              is_load,
  input  logic              we_regfile,
  output logic              rf_we,
  output logic [DWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] pc_plus4,
  output logic [31:0]       instret,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [15:0]       tcnt;
  logic              expired;
  logic [DWIDTH-1:0] next_pc;
  logic              unused_jump_hi;

  // Only the 26-bit J-type index participates in the target.
  assign unused_jump_hi = ^jump_addr[DWIDTH-1:26];

  assign pc_plus4      = pc + DWIDTH'(4);
  assign bus.imem_addr = pc;
  assign expired       = (tcnt == TLAST);

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state: an ack always beats an expiring wait.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (bus.imem_ack)  state_next = S_EXEC;
        else if (expired)  state_next = S_HALT;
      end
      S_EXEC:  state_next = (we_dmem || is_load) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ack)  state_next = S_WB;
        else if (expired)  state_next = S_HALT;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Outputs are gated by rst_n so nothing is requested while reset is held.
  always_comb begin
    bus.imem_req = rst_n && (state == S_FETCH);
    bus.dmem_req = rst_n && (state == S_MEM);
    bus.dmem_we  = rst_n && (state == S_MEM) && we_dmem;
    rf_we        = rst_n && (state == S_WB) && we_regfile;
  end

  // Wait counter restarts whenever the state changes, counts while waiting for an ack.
  always_ff @(posedge clk) begin
    if (!rst_n)                                     tcnt <= '0;
    else if (state_next != state)                   tcnt <= '0;
    else if ((state == S_FETCH) || (state == S_MEM)) tcnt <= tcnt + 16'd1;
  end

  // Next PC from the decoder outputs held stable since EXEC.
  always_comb begin
    case (jump_type)
      3'b001:         next_pc = alu_zero ? (pc_plus4 + (imm << 2)) : pc_plus4;
      3'b010, 3'b100: next_pc = {pc_plus4[DWIDTH-1:28], jump_addr[25:0], 2'b00};
      3'b011:         next_pc = rs1_data;
      default:        next_pc = pc_plus4;
    endcase
  end

  // Architectural state: IR latches on fetch ack, PC/instret retire in WB, bus_err is sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr   <= '0;
      instret <= '0;
      bus_err <= 1'b0;
    end else begin
      if ((state == S_FETCH) && bus.imem_ack) instr <= bus.imem_rdata;
      if (state == S_WB) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
      end
      if (state_next == S_HALT) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - self-checking bench for mc_sequencer
module tb_mc_sequencer;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] instr, jump_addr, imm, rs1_data, pc, pc_plus4;
  logic [2:0]    jump_type;
  logic          alu_zero, we_dmem, is_load, we_regfile, rf_we, bus_err;
  logic [31:0]   instret;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   m_pc, m_instret;

  always #5 clk = ~clk;

  mc_sequencer_if #(.DWIDTH(DW)) bus ();

  mc_sequencer #(.DWIDTH(DW), .RESET_PC(32'h0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .instr(instr),
    .jump_type(jump_type), .jump_addr(jump_addr), .imm(imm), .alu_zero(alu_zero),
    .rs1_data(rs1_data), .we_dmem(we_dmem), .is_load(is_load), .we_regfile(we_regfile),
    .rf_we(rf_we), .pc(pc), .pc_plus4(pc_plus4), .instret(instret), .bus_err(bus_err)
  );

  // Architectural next-PC rule written as plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [2:0] jt,
                                           input logic [31:0] ja, im, rs1, input logic z);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jt == 3'd1) return z ? seq + im * 32'd4 : seq;
    if (jt == 3'd2 || jt == 3'd4) return (seq & 32'hF000_0000) + (ja % 32'h0400_0000) * 32'd4;
    if (jt == 3'd3) return rs1;
    return seq;
  endfunction

  // Plays instruction and data memory for one instruction, reporting what was observed.
  task automatic run_instr(input logic [2:0] jt, input logic [31:0] ja, im, rs1, rdata,
                           input logic z, ld, st, wr, input int idelay, ddelay,
                           output logic [31:0] faddr, output int cyc, icyc, rfp, dcyc,
                           output logic dwe, output logic [31:0] link, ir, output logic halted);
    int   icnt, dcnt;
    logic fetched;
    jump_type = jt; jump_addr = ja; imm = im; rs1_data = rs1; alu_zero = z;
    is_load = ld; we_dmem = st; we_regfile = wr; bus.imem_rdata = rdata;
    faddr = 32'hDEAD_BEEF; cyc = 0; icyc = 0; rfp = 0; dcyc = 0; dwe = 1'b0;
    link = 32'h0; ir = 32'h0; halted = 1'b0; fetched = 1'b0; icnt = 0; dcnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (bus_err) begin halted = 1'b1; break; end
      if (bus.imem_req && fetched) break;
      cyc++;
      if (bus.imem_req) begin
        if (icyc == 0) faddr = bus.imem_addr;
        icyc++;
        bus.imem_ack = (icnt == idelay);
        icnt++;
        if (bus.imem_ack) fetched = 1'b1;
      end else bus.imem_ack = 1'b0;
      if (bus.dmem_req) begin
        dcyc++;
        dwe = dwe | bus.dmem_we;
        bus.dmem_ack = (dcnt == ddelay);
        dcnt++;
      end else bus.dmem_ack = 1'b0;
      @(negedge clk);
      if (rf_we) begin rfp++; link = pc_plus4; end
      ir = instr;
      @(posedge clk); #1;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000", {bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we});
    end
    @(posedge clk); #1;
    checks++;
    if ({pc, instr, instret, bus_err} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_regs: pc=%h instr=%h instret=%0d bus_err=%b expected all zero", pc, instr, instret, bus_err);
    end
    rst_n = 1'b1; #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_fetch: imem_req=%b addr=%h expected 1/00000000", bus.imem_req, bus.imem_addr);
    end
    m_pc = 32'h0; m_instret = 32'h0;
  endtask

  task automatic test_addi_stream();
    logic [31:0] fa, lk, ir; int c, ic, rp, dc; logic dw, h;
    for (int i = 0; i < 3; i++) begin
      run_instr(3'd0, 32'h0, 32'h1, 32'h0, 32'h2001_0001 + i, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
      checks++;
      if (fa !== m_pc || c !== 3 || rp !== 1) begin
        errors++; $display("FAIL addi_%0d: addr=%h cyc=%0d rf=%0d expected addr=%h cyc=3 rf=1", i, fa, c, rp, m_pc);
      end
      m_pc = m_pc + 32'd4; m_instret++;
    end
    checks++;
    if (instret !== 32'd3) begin errors++; $display("FAIL addi_instret: got %0d expected 3", instret); end
  endtask

  task automatic test_branch();
    logic [31:0] fa, lk, ir; int c, ic, rp, dc; logic dw, h;
    for (int z = 1; z >= 0; z--) begin
      run_instr(3'd3, 32'h0, 32'h0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
      checks++;
      if (pc !== 32'h10) begin errors++; $display("FAIL jr_to_10: got %h expected 00000010", pc); end
      run_instr(3'd1, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h1000_FFFF, z[0], 1'b0, 1'b0, 1'b0, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
      checks++;
      if (pc !== (z == 1 ? 32'h04 : 32'h14) || fa !== 32'h10) begin
        errors++; $display("FAIL beq_z%0d: pc=%h fetch=%h expected pc=%h fetch=00000010", z, pc, fa, (z == 1 ? 32'h04 : 32'h14));
      end
      m_instret += 2;
    end
    m_pc = pc;
  endtask

  task automatic test_jumps();
    logic [31:0] fa, lk, ir, ja; int c, ic, rp, dc; logic dw, h;
    run_instr(3'd3, 32'h0, 32'h0, 32'hF000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
    run_instr(3'd4, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
    checks++;
    if (pc !== 32'hF000_0400) begin errors++; $display("FAIL j_target: got %h expected f0000400", pc); end
    run_instr(3'd3, 32'h0, 32'h0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
    checks++;
    if (pc !== 32'h80) begin errors++; $display("FAIL jr_target: got %h expected 00000080", pc); end
    ja = $urandom;
    run_instr(3'd2, ja, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
    checks++;
    if (rp !== 1 || lk !== 32'h84 || pc !== ref_next(32'h80, 3'd2, ja, 32'h0, 32'h0, 1'b0)) begin
      errors++; $display("FAIL jal: rf=%0d link=%h pc=%h expected rf=1 link=00000084 pc=%h", rp, lk, pc, ref_next(32'h80, 3'd2, ja, 32'h0, 32'h0, 1'b0));
    end
    m_pc = pc; m_instret += 4;
  endtask

  task automatic test_mem();
    logic [31:0] fa, lk, ir; int c, ic, rp, dc; logic dw, h;
    run_instr(3'd0, 32'h0, 32'h0, 32'h0, 32'h8C01_0000, 1'b0, 1'b1, 1'b0, 1'b1, 0, 5, fa, c, ic, rp, dc, dw, lk, ir, h);
    checks++;
    if (dc !== 6 || dw !== 1'b0 || rp !== 1 || c !== 9) begin
      errors++; $display("FAIL lw_delay5: dreq=%0d we=%b rf=%0d cpi=%0d expected 6/0/1/9", dc, dw, rp, c);
    end
    run_instr(3'd0, 32'h0, 32'h0, 32'h0, 32'hAC01_0000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
    checks++;
    if (dc !== 1 || dw !== 1'b1 || rp !== 0 || c !== 4) begin
      errors++; $display("FAIL sw: dreq=%0d we=%b rf=%0d cpi=%0d expected 1/1/0/4", dc, dw, rp, c);
    end
    m_pc = m_pc + 32'd8; m_instret += 2;
  endtask

  task automatic test_random();
    logic [31:0] fa, lk, ir, ja, im, rs, rd, exp_pc; int c, ic, rp, dc, id, dd, kind, exp_c;
    logic dw, h, z, wr, ld, st; logic [2:0] jt;
    for (int i = 0; i < 40; i++) begin
      jt = 3'($urandom_range(0, 7)); ja = $urandom; im = $urandom; rs = $urandom; rd = $urandom;
      z = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1)); kind = $urandom_range(0, 2);
      ld = (kind == 1); st = (kind == 2);
      id = $urandom_range(0, TO - 1); dd = $urandom_range(0, TO - 1);
      exp_pc = ref_next(m_pc, jt, ja, im, rs, z);
      exp_c = (id + 1) + 1 + ((ld || st) ? dd + 1 : 0) + 1;
      run_instr(jt, ja, im, rs, rd, z, ld, st, wr, id, dd, fa, c, ic, rp, dc, dw, lk, ir, h);
      m_instret++;
      checks++;
      if (fa !== m_pc) begin errors++; $display("FAIL rnd%0d_fetch: got %h expected %h", i, fa, m_pc); end
      checks++;
      if (pc !== exp_pc) begin errors++; $display("FAIL rnd%0d_next_pc: got %h expected %h (jt=%0d)", i, pc, exp_pc, jt); end
      checks++;
      if (c !== exp_c) begin errors++; $display("FAIL rnd%0d_cycles: got %0d expected %0d", i, c, exp_c); end
      checks++;
      if (rp !== int'(wr) || dw !== st) begin errors++; $display("FAIL rnd%0d_strobes: rf=%0d dwe=%b expected %0d/%b", i, rp, dw, wr, st); end
      checks++;
      if (ir !== rd || (wr && lk !== m_pc + 32'd4)) begin errors++; $display("FAIL rnd%0d_ir_link: ir=%h link=%h expected %h/%h", i, ir, lk, rd, m_pc + 32'd4); end
      checks++;
      if (instret !== m_instret) begin errors++; $display("FAIL rnd%0d_instret: got %0d expected %0d", i, instret, m_instret); end
      m_pc = exp_pc;
    end
  endtask

  task automatic test_timeout();
    logic [31:0] fa, lk, ir; int c, ic, rp, dc; logic dw, h;
    run_instr(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, TO - 1, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
    m_instret++;
    checks++;
    if (h !== 1'b0 || ic !== TO || bus_err !== 1'b0) begin
      errors++; $display("FAIL ack_last_cycle: halted=%b fetch_cycles=%0d expected 0/%0d", h, ic, TO);
    end
    run_instr(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1000, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
    checks++;
    if (h !== 1'b1 || ic !== TO || bus_err !== 1'b1) begin
      errors++; $display("FAIL fetch_timeout: halted=%b fetch_cycles=%0d expected 1/%0d", h, ic, TO);
    end
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we} !== 4'b0 || instret !== m_instret || bus_err !== 1'b1) begin
        errors++; $display("FAIL halt_%0d: req=%b instret=%0d err=%b expected 0000/%0d/1", k,
                            {bus.imem_req, bus.dmem_req, bus.dmem_we, rf_we}, instret, bus_err, m_instret);
      end
    end
    test_reset();
    run_instr(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1000, fa, c, ic, rp, dc, dw, lk, ir, h);
    checks++;
    if (h !== 1'b1 || dc !== TO || rp !== 0) begin
      errors++; $display("FAIL mem_timeout: halted=%b dreq_cycles=%0d rf=%0d expected 1/%0d/0", h, dc, rp, TO);
    end
    test_reset();
  endtask

  task automatic test_reset_mid_mem();
    logic [31:0] fa, lk, ir; int c, ic, rp, dc; logic dw, h;
    run_instr(3'd3, 32'h0, 32'h0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
    checks++;
    if (pc !== 32'h44) begin errors++; $display("FAIL pre_reset_pc: got %h expected 00000044", pc); end
    jump_type = 3'd0; is_load = 1'b1; we_dmem = 1'b0; we_regfile = 1'b1;
    bus.imem_ack = 1'b1;
    @(posedge clk); #1; bus.imem_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req: got %b expected 1", bus.dmem_req); end
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b0; bus.dmem_ack = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pc !== 32'h0 || bus.dmem_req !== 1'b0 || instret !== 32'h0) begin
      errors++; $display("FAIL mid_mem_reset: pc=%h dmem_req=%b instret=%0d expected 0/0/0", pc, bus.dmem_req, instret);
    end
    rst_n = 1'b1; #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL late_ack_state: dmem_req=%b imem_req=%b addr=%h expected 0/1/0", bus.dmem_req, bus.imem_req, bus.imem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.imem_req !== 1'b1 || rf_we !== 1'b0 || instret !== 32'h0) begin
      errors++; $display("FAIL late_ack_ignored: imem_req=%b rf_we=%b instret=%0d expected 1/0/0", bus.imem_req, rf_we, instret);
    end
    bus.dmem_ack = 1'b0; is_load = 1'b0;
    run_instr(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, fa, c, ic, rp, dc, dw, lk, ir, h);
    checks++;
    if (fa !== 32'h0 || pc !== 32'h4 || c !== 3) begin
      errors++; $display("FAIL post_reset_instr: fetch=%h pc=%h cyc=%0d expected 0/4/3", fa, pc, c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    jump_type = 3'd0; jump_addr = '0; imm = '0; alu_zero = 1'b0; rs1_data = '0;
    we_dmem = 1'b0; is_load = 1'b0; we_regfile = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_addi_stream();
    test_branch();
    test_jumps();
    test_mem();
    test_random();
    test_timeout();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
